axi_write_arbiter: RTL and testbench
====================================

// Module: axi_write_arbiter
// PURPOSE
//  Two-requester arbiter for a single AXI write slave port (AW/W/B channels).
//  Sits between two write masters and one write-slave datapath.
//  Grants one master per transaction, locks the grant through the whole burst
//  and routes the B response back to the granted master. One transaction in flight.
// PARAMETERS
//  ADDR_W   32  AWADDR width
//  DATA_W   32  WDATA width; WSTRB width = DATA_W/8
//  ID_W      4  master-side AWID width; slave-side AWID is ID_W+1
// PORTS
//  ACLK             in   1        clock, all logic on rising edge
//  ARESETn          in   1        asynchronous active-low reset
//  Mn_AWVALID       in   1        n=0,1: address request
//  Mn_AWREADY       out  1        address accepted for master n
//  Mn_AWID/AWADDR   in   ID_W/ADDR_W  transaction ID / start address
//  Mn_AWLEN/AWSIZE/AWBURST in 4/3/2   burst attributes
//  Mn_WDATA/WSTRB/WLAST/WVALID in DATA_W/DATA_W/8/1/1  write data beat
//  Mn_WREADY        out  1        beat accepted for master n
//  Mn_BVALID/BRESP/BID out 1/2/ID_W  response to master n
//  Mn_BREADY        in   1        master n accepts response
//  S_AW*,S_W*       out  as above  muxed slave-side AW/W; S_AWID is ID_W+1
//  S_AWREADY,S_WREADY in 1        slave handshakes
//  S_BVALID/S_BRESP/S_BID in 1/2/ID_W+1  slave response
//  S_BREADY         out  1        forwarded BREADY of granted master
//  busy             out  1        high from grant until B handshake completes
// BEHAVIOUR
//  FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE. Reset: IDLE, grant=0, last_grant=1,
//   all outputs 0 (all VALID/READY low, S_* payloads 0, busy 0).
//  IDLE: if any Mn_AWVALID, pick winner, register grant, -> ADDR next cycle.
//   Round-robin: both requesting -> master != last_grant; one requesting -> it.
//  ADDR: S_AWVALID=Mgrant_AWVALID, payload muxed combinationally from grant;
//   S_AWID={grant, Mgrant_AWID}. Mgrant_AWREADY=S_AWREADY; other master AWREADY=0.
//   On S_AWVALID&S_AWREADY: last_grant<=grant, -> DATA.
//  DATA: W channel muxed from grant; non-granted WREADY=0. On handshake with
//   WLAST=1 -> RESP. Beat count not checked; WLAST alone ends the burst.
//  RESP: Mgrant_BVALID=S_BVALID, BRESP passed, Mgrant_BID=S_BID[ID_W-1:0];
//   S_BREADY=Mgrant_BREADY. On B handshake -> IDLE. Arbitration for next
//   transaction starts in IDLE the following cycle (min 1 idle cycle between grants).
//  Latency: AWVALID to S_AWVALID = 1 cycle; W and B paths combinational.
//  S_BVALID outside RESP: ignored, S_BREADY=0. S_BID[ID_W] != grant: still routed
//   to grant (single outstanding), RESP unaffected.
//  Non-granted master's AWVALID held: it wins next IDLE under round-robin.
//  Reset mid-transaction: immediate return to IDLE; in-flight burst abandoned.
//  busy = (state != IDLE).
// CONFIGURATION
//  WARB_FIXED_PRIO_EN defined: master 0 always wins when both request in IDLE;
//   last_grant unused. Undefined (default): round-robin as above.
// TESTING
//  M0 alone, AWLEN=3, 4 beats, slave ready always -> S_AWID={0,M0_AWID}, 4 S_W beats,
//   M0_BVALID with BRESP=00; M1_* READY/VALID stay 0 throughout.
//  M0,M1 request same cycle after reset -> M0 granted (last_grant=1), then M1 next;
//   with WARB_FIXED_PRIO_EN and M0 re-requesting -> M0 granted twice.
//  M1 burst with S_WREADY toggling 1,0,1,0 -> each beat passed once; RESP only after
//   WLAST handshake; S_BRESP=10 -> M1_BRESP=10.
//  M0_BREADY held low 3 cycles while S_BVALID=1 -> S_BREADY=0, stays in RESP, busy=1;
//   BREADY high -> IDLE, busy=0 next cycle.
//  ARESETn low during DATA beat 2 -> all outputs 0 asynchronously, busy=0; after
//   release a new M1 request is granted normally.
//  S_BVALID pulsed in IDLE -> no Mn_BVALID, S_BREADY=0.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter: one grant per burst, AW/W/B routing locked to the winner until B completes.
// Build option WARB_FIXED_PRIO_EN: master 0 wins simultaneous requests; default is round-robin.
module axi_write_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                M0_AWVALID,
    output logic                M0_AWREADY,
    input  logic [ID_W-1:0]     M0_AWID,
    input  logic [ADDR_W-1:0]   M0_AWADDR,
    input  logic [3:0]          M0_AWLEN,
    input  logic [2:0]          M0_AWSIZE,
    input  logic [1:0]          M0_AWBURST,
    input  logic [DATA_W-1:0]   M0_WDATA,
    input  logic [DATA_W/8-1:0] M0_WSTRB,
    input  logic                M0_WLAST,
    input  logic                M0_WVALID,
    output logic                M0_WREADY,
    output logic                M0_BVALID,
    output logic [1:0]          M0_BRESP,
    output logic [ID_W-1:0]     M0_BID,
    input  logic                M0_BREADY,
    input  logic                M1_AWVALID,
    output logic                M1_AWREADY,
    input  logic [ID_W-1:0]     M1_AWID,
    input  logic [ADDR_W-1:0]   M1_AWADDR,
    input  logic [3:0]          M1_AWLEN,
    input  logic [2:0]          M1_AWSIZE,
    input  logic [1:0]          M1_AWBURST,
    input  logic [DATA_W-1:0]   M1_WDATA,
    input  logic [DATA_W/8-1:0] M1_WSTRB,
    input  logic                M1_WLAST,
    input  logic                M1_WVALID,
    output logic                M1_WREADY,
    output logic                M1_BVALID,
    output logic [1:0]          M1_BRESP,
    output logic [ID_W-1:0]     M1_BID,
    input  logic                M1_BREADY,
    output logic                S_AWVALID,
    input  logic                S_AWREADY,
    output logic [ID_W:0]       S_AWID,
    output logic [ADDR_W-1:0]   S_AWADDR,
    output logic [3:0]          S_AWLEN,
    output logic [2:0]          S_AWSIZE,
    output logic [1:0]          S_AWBURST,
    output logic [DATA_W-1:0]   S_WDATA,
    output logic [DATA_W/8-1:0] S_WSTRB,
    output logic                S_WLAST,
    output logic                S_WVALID,
    input  logic                S_WREADY,
    input  logic                S_BVALID,
    input  logic [1:0]          S_BRESP,
    input  logic [ID_W:0]       S_BID,
    output logic                S_BREADY,
    output logic                busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_grant;
    logic   w_grant_next;
    logic   w_winner;
    logic   w_in_addr, w_in_data, w_in_resp;
    logic   w_aw_hs, w_w_hs, w_b_hs;
    logic   w_unused_bid_msb;

    logic [1:0] w_m_awvalid, w_m_wvalid, w_m_wlast, w_m_bready;
    logic [1:0] w_own, w_awready, w_wready, w_bvalid;
    logic [1:0]      w_bresp [2];
    logic [ID_W-1:0] w_bid   [2];

    assign w_m_awvalid = {M1_AWVALID, M0_AWVALID};
    assign w_m_wvalid  = {M1_WVALID,  M0_WVALID};
    assign w_m_wlast   = {M1_WLAST,   M0_WLAST};
    assign w_m_bready  = {M1_BREADY,  M0_BREADY};

    // The slave-side ID MSB is ignored: with one transaction in flight the
    // response always belongs to the current grant.
    assign w_unused_bid_msb = S_BID[ID_W];

`ifdef WARB_FIXED_PRIO_EN
    assign w_winner = ~M0_AWVALID;
`else
    logic r_last_grant;

    assign w_winner = (M0_AWVALID & M1_AWVALID) ? ~r_last_grant : M1_AWVALID;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_last_grant <= 1'b1;
        end else if (w_aw_hs) begin
            r_last_grant <= r_grant;
        end
    end
`endif

    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_aw_hs   = S_AWVALID & S_AWREADY;
    assign w_w_hs    = S_WVALID & S_WREADY;
    assign w_b_hs    = S_BVALID & S_BREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (M0_AWVALID | M1_AWVALID) begin
                    w_state_next = ST_ADDR;
                    w_grant_next = w_winner;
                end
            end
            ST_ADDR: if (w_aw_hs)            w_state_next = ST_DATA;
            ST_DATA: if (w_w_hs && S_WLAST)  w_state_next = ST_RESP;
            ST_RESP: if (w_b_hs)             w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    // Slave-side payloads are forced to zero outside their phase so idle/reset outputs are clean.
    assign S_AWVALID = w_in_addr & w_m_awvalid[r_grant];
    assign S_AWID    = w_in_addr ? {r_grant, (r_grant ? M1_AWID : M0_AWID)} : '0;
    assign S_AWADDR  = w_in_addr ? (r_grant ? M1_AWADDR  : M0_AWADDR)  : '0;
    assign S_AWLEN   = w_in_addr ? (r_grant ? M1_AWLEN   : M0_AWLEN)   : '0;
    assign S_AWSIZE  = w_in_addr ? (r_grant ? M1_AWSIZE  : M0_AWSIZE)  : '0;
    assign S_AWBURST = w_in_addr ? (r_grant ? M1_AWBURST : M0_AWBURST) : '0;

    assign S_WVALID  = w_in_data & w_m_wvalid[r_grant];
    assign S_WLAST   = w_in_data & w_m_wlast[r_grant];
    assign S_WDATA   = w_in_data ? (r_grant ? M1_WDATA : M0_WDATA) : '0;
    assign S_WSTRB   = w_in_data ? (r_grant ? M1_WSTRB : M0_WSTRB) : '0;

    assign S_BREADY  = w_in_resp & w_m_bready[r_grant];
    assign busy      = (r_state != ST_IDLE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign w_own[gi]     = (gi == 1) ? r_grant : ~r_grant;
            assign w_awready[gi] = w_in_addr & w_own[gi] & S_AWREADY;
            assign w_wready[gi]  = w_in_data & w_own[gi] & S_WREADY;
            assign w_bvalid[gi]  = w_in_resp & w_own[gi] & S_BVALID;
            assign w_bresp[gi]   = (w_in_resp & w_own[gi]) ? S_BRESP : 2'b00;
            assign w_bid[gi]     = (w_in_resp & w_own[gi]) ? S_BID[ID_W-1:0] : '0;
        end
    endgenerate

    assign M0_AWREADY = w_awready[0];
    assign M1_AWREADY = w_awready[1];
    assign M0_WREADY  = w_wready[0];
    assign M1_WREADY  = w_wready[1];
    assign M0_BVALID  = w_bvalid[0];
    assign M1_BVALID  = w_bvalid[1];
    assign M0_BRESP   = w_bresp[0];
    assign M1_BRESP   = w_bresp[1];
    assign M0_BID     = w_bid[0];
    assign M1_BID     = w_bid[1];

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized scoreboard bench for axi_write_arbiter: a grant-order model predicts AW/W/B traffic,
// a monitor pops expectations on every handshake.
module tb_axi_write_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int AW_E   = 1 + ID_W + ADDR_W + 4 + 3 + 2;
    localparam int W_E    = 1 + DATA_W + DATA_W/8 + 1;
    localparam int B_E    = 1 + ID_W + 2;

    typedef struct packed {
        logic              m;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [1:0]        bresp;
    } tx_t;

    logic ACLK, ARESETn;
    logic M0_AWVALID, M0_AWREADY, M1_AWVALID, M1_AWREADY;
    logic [ID_W-1:0] M0_AWID, M1_AWID, M0_BID, M1_BID;
    logic [ADDR_W-1:0] M0_AWADDR, M1_AWADDR, S_AWADDR;
    logic [3:0] M0_AWLEN, M1_AWLEN, S_AWLEN;
    logic [2:0] M0_AWSIZE, M1_AWSIZE, S_AWSIZE;
    logic [1:0] M0_AWBURST, M1_AWBURST, S_AWBURST;
    logic [DATA_W-1:0] M0_WDATA, M1_WDATA, S_WDATA;
    logic [DATA_W/8-1:0] M0_WSTRB, M1_WSTRB, S_WSTRB;
    logic M0_WLAST, M0_WVALID, M0_WREADY, M1_WLAST, M1_WVALID, M1_WREADY;
    logic M0_BVALID, M0_BREADY, M1_BVALID, M1_BREADY;
    logic [1:0] M0_BRESP, M1_BRESP, S_BRESP;
    logic S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY, busy;
    logic [ID_W:0] S_AWID, S_BID;

    axi_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY), .M0_AWID(M0_AWID), .M0_AWADDR(M0_AWADDR),
        .M0_AWLEN(M0_AWLEN), .M0_AWSIZE(M0_AWSIZE), .M0_AWBURST(M0_AWBURST),
        .M0_WDATA(M0_WDATA), .M0_WSTRB(M0_WSTRB), .M0_WLAST(M0_WLAST), .M0_WVALID(M0_WVALID),
        .M0_WREADY(M0_WREADY), .M0_BVALID(M0_BVALID), .M0_BRESP(M0_BRESP), .M0_BID(M0_BID),
        .M0_BREADY(M0_BREADY),
        .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY), .M1_AWID(M1_AWID), .M1_AWADDR(M1_AWADDR),
        .M1_AWLEN(M1_AWLEN), .M1_AWSIZE(M1_AWSIZE), .M1_AWBURST(M1_AWBURST),
        .M1_WDATA(M1_WDATA), .M1_WSTRB(M1_WSTRB), .M1_WLAST(M1_WLAST), .M1_WVALID(M1_WVALID),
        .M1_WREADY(M1_WREADY), .M1_BVALID(M1_BVALID), .M1_BRESP(M1_BRESP), .M1_BID(M1_BID),
        .M1_BREADY(M1_BREADY),
        .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID), .S_AWADDR(S_AWADDR),
        .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .S_BVALID(S_BVALID), .S_BRESP(S_BRESP), .S_BID(S_BID),
        .S_BREADY(S_BREADY), .busy(busy)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int total = 0;
    int bad   = 0;

    logic [AW_E-1:0] q_aw [$];
    logic [W_E-1:0]  q_w  [$];
    logic [B_E-1:0]  q_b  [$];

    // Grant-order model state: the master that won most recently (reset value 1).
    bit m_last = 1'b1;

    tx_t         sq      [3];
    logic [31:0] sq_data [3][16];
    logic [3:0]  sq_strb [3][16];
    int          sq_n;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected handshake with empty expectation queue", name);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: handshake did not occur within cycle bound", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({M0_AWREADY, M0_WREADY, M0_BVALID, M0_BRESP, M0_BID,
                     M1_AWREADY, M1_WREADY, M1_BVALID, M1_BRESP, M1_BID,
                     S_AWVALID, S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST,
                     S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY, busy});
    endfunction

    function automatic bit pick(input bit p0, input bit p1);
        if (p0 && p1) begin
`ifdef WARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~m_last;
`endif
        end
        return p1;
    endfunction

    function automatic bit awready_of(input bit m);
        return m ? M1_AWREADY : M0_AWREADY;
    endfunction

    function automatic bit wready_of(input bit m);
        return m ? M1_WREADY : M0_WREADY;
    endfunction

    task automatic drive_aw(input bit m, input bit v, input tx_t t);
        if (m) begin
            M1_AWVALID = v; M1_AWID = t.id; M1_AWADDR = t.addr;
            M1_AWLEN = t.len; M1_AWSIZE = t.size; M1_AWBURST = t.burst;
        end else begin
            M0_AWVALID = v; M0_AWID = t.id; M0_AWADDR = t.addr;
            M0_AWLEN = t.len; M0_AWSIZE = t.size; M0_AWBURST = t.burst;
        end
    endtask

    task automatic set_awvalid(input bit m, input bit v);
        if (m) M1_AWVALID = v;
        else   M0_AWVALID = v;
    endtask

    task automatic drive_w(input bit m, input bit v, input logic [31:0] d, input logic [3:0] s, input bit l);
        if (m) begin
            M1_WVALID = v; M1_WDATA = d; M1_WSTRB = s; M1_WLAST = l;
        end else begin
            M0_WVALID = v; M0_WDATA = d; M0_WSTRB = s; M0_WLAST = l;
        end
    endtask

    task automatic set_bready(input bit m, input bit v);
        if (m) M1_BREADY = v;
        else   M0_BREADY = v;
    endtask

    task automatic wait_aw(input bit m, output logic [ID_W:0] cap);
        int cyc = 0;
        bit hs  = 1'b0;
        cap = '0;
        while (!hs) begin
            @(negedge ACLK);
            S_AWREADY = 1'($urandom_range(0, 1));
            #1;
            hs  = awready_of(m);
            cap = S_AWID;
            cyc++;
            if (cyc > 300) timeout_fail("aw_wait");
        end
    endtask

    task automatic make_tx(input int k, input bit m);
        sq[k].m     = m;
        sq[k].id    = 4'($urandom);
        sq[k].addr  = $urandom;
        sq[k].len   = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        sq[k].size  = 3'($urandom_range(0, 2));
        sq[k].burst = 2'($urandom_range(0, 2));
        sq[k].bresp = 2'($urandom);
        for (int b = 0; b < 16; b++) begin
            sq_data[k][b] = $urandom;
            sq_strb[k][b] = 4'($urandom);
        end
    endtask

    task automatic push_expect(input int k, input bit with_b);
        tx_t t = sq[k];
        q_aw.push_back({t.m, t.id, t.addr, t.len, t.size, t.burst});
        for (int b = 0; b <= int'(t.len); b++)
            q_w.push_back({t.m, sq_data[k][b], sq_strb[k][b], (b == int'(t.len))});
        if (with_b) q_b.push_back({t.m, t.id, t.bresp});
    endtask

    task automatic serve(input int k);
        tx_t t;
        int cyc, b, dly;
        bit v, br, hs, other;
        logic [ID_W:0] cap_id;
        t = sq[k];
        other = ~t.m;
        wait_aw(t.m, cap_id);
        b = 0;
        cyc = 0;
        while (b <= int'(t.len)) begin
            @(negedge ACLK);
            set_awvalid(t.m, 1'b0);
            S_AWREADY = 1'b0;
            v = ($urandom_range(0, 3) != 0);
            drive_w(t.m, v, sq_data[k][b], sq_strb[k][b], (b == int'(t.len)));
            drive_w(other, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
            S_WREADY = 1'($urandom_range(0, 1));
            #1;
            if (v && wready_of(t.m)) b++;
            cyc++;
            if (cyc > 300) timeout_fail("w_wait");
        end
        dly = $urandom_range(0, 2);
        cyc = 0;
        hs  = 1'b0;
        while (!hs) begin
            @(negedge ACLK);
            drive_w(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
            drive_w(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
            S_WREADY = 1'b0;
            if (cyc == dly) begin
                S_BVALID = 1'b1;
                S_BRESP  = t.bresp;
                S_BID    = {1'($urandom_range(0, 1)), cap_id[ID_W-1:0]};
            end
            br = ($urandom_range(0, 2) != 0);
            set_bready(t.m, br);
            set_bready(other, 1'($urandom_range(0, 1)));
            #1;
            if (S_BVALID && !br) begin
                check("bready_held_low", 128'(S_BREADY), 128'(0));
                check("busy_in_resp", 128'(busy), 128'(1));
            end
            hs = S_BVALID && S_BREADY;
            cyc++;
            if (cyc > 300) timeout_fail("b_wait");
        end
        @(negedge ACLK);
        S_BVALID = 1'b0;
        S_BRESP  = 2'b00;
        S_BID    = '0;
        set_bready(1'b0, 1'b0);
        set_bready(1'b1, 1'b0);
        for (int j = k + 1; j < sq_n; j++) begin
            if (sq[j].m == t.m) begin
                drive_aw(t.m, 1'b1, sq[j]);
                break;
            end
        end
        #1;
        check("busy_after_b", 128'(busy), 128'(0));
    endtask

    // Model: the pending set is arbitrated per grant; a re-requesting winner rejoins the set.
    task automatic run_round(input bit [1:0] mask, input bit rereq);
        bit p0, p1, w;
        p0 = mask[0];
        p1 = mask[1];
        sq_n = 0;
        w = pick(p0, p1);
        m_last = w;
        make_tx(sq_n, w);
        sq_n++;
        if (w) p1 = rereq;
        else   p0 = rereq;
        while (p0 || p1) begin
            w = pick(p0, p1);
            m_last = w;
            make_tx(sq_n, w);
            sq_n++;
            if (w) p1 = 1'b0;
            else   p0 = 1'b0;
        end
        for (int k = 0; k < sq_n; k++) push_expect(k, 1'b1);
        @(negedge ACLK);
        for (int m = 0; m < 2; m++) begin
            if (mask[m]) begin
                for (int k = 0; k < sq_n; k++) begin
                    if (sq[k].m == 1'(m)) begin
                        drive_aw(1'(m), 1'b1, sq[k]);
                        break;
                    end
                end
            end
        end
        for (int k = 0; k < sq_n; k++) serve(k);
    endtask

    logic [AW_E-1:0] e_aw;
    logic [W_E-1:0]  e_w;
    logic [B_E-1:0]  e_b;

    always begin
        @(negedge ACLK);
        #2;
        if (ARESETn) begin
            if (S_AWVALID && S_AWREADY) begin
                if (q_aw.size() == 0) fail_now("aw_unexpected");
                else begin
                    e_aw = q_aw.pop_front();
                    check("aw_payload", 128'({S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST}), 128'(e_aw));
                    check("aw_route", 128'({M1_AWREADY, M0_AWREADY}), 128'({e_aw[AW_E-1], ~e_aw[AW_E-1]}));
                end
            end
            if (S_WVALID && S_WREADY) begin
                if (q_w.size() == 0) fail_now("w_unexpected");
                else begin
                    e_w = q_w.pop_front();
                    check("w_beat", 128'({M1_WREADY, M0_WREADY, S_WDATA, S_WSTRB, S_WLAST}),
                          128'({e_w[W_E-1], ~e_w[W_E-1], e_w[W_E-2:0]}));
                end
            end
            if ((M0_BVALID && M0_BREADY) || (M1_BVALID && M1_BREADY)) begin
                if (q_b.size() == 0) fail_now("b_unexpected");
                else begin
                    e_b = q_b.pop_front();
                    check("b_resp", 128'({M1_BVALID, M0_BVALID, M0_BID | M1_BID, M0_BRESP | M1_BRESP}),
                          128'({e_b[B_E-1], ~e_b[B_E-1], e_b[B_E-2:0]}));
                end
            end
        end
    end

    initial begin
        tx_t t;
        logic [ID_W:0] cap;
        ARESETn = 1'b0;
        t = '0;
        drive_aw(1'b0, 1'b0, t);
        drive_aw(1'b1, 1'b0, t);
        drive_w(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        drive_w(1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        M0_BREADY = 1'b0; M1_BREADY = 1'b0;
        S_AWREADY = 1'b0; S_WREADY = 1'b0;
        S_BVALID = 1'b0; S_BRESP = 2'b00; S_BID = '0;

        repeat (3) @(negedge ACLK);
        #1;
        check("reset_outputs", all_outs(), 128'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check("idle_outputs", all_outs(), 128'(0));

        // Simultaneous first requests: M0 wins (last_grant resets to 1), then M1.
        run_round(2'b11, 1'b0);
        for (int r = 0; r < 30; r++)
            run_round(2'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0));

        // Stray slave response while idle must not reach either master.
        @(negedge ACLK);
        S_BVALID = 1'b1; S_BRESP = 2'b11; S_BID = '1;
        M0_BREADY = 1'b1; M1_BREADY = 1'b1;
        #1;
        check("idle_bvalid_ignored", 128'({M1_BVALID, M0_BVALID, M1_BRESP, M0_BRESP, M1_BID, M0_BID, S_BREADY, busy}), 128'(0));
        @(negedge ACLK);
        S_BVALID = 1'b0; S_BRESP = 2'b00; S_BID = '0;
        M0_BREADY = 1'b0; M1_BREADY = 1'b0;

        // Reset asserted while the second data beat is being presented.
        sq_n = 1;
        make_tx(0, 1'b0);
        sq[0].len = 4'd3;
        push_expect(0, 1'b0);
        @(negedge ACLK);
        drive_aw(1'b0, 1'b1, sq[0]);
        wait_aw(1'b0, cap);
        @(negedge ACLK);
        set_awvalid(1'b0, 1'b0);
        S_AWREADY = 1'b0;
        drive_w(1'b0, 1'b1, sq_data[0][0], sq_strb[0][0], 1'b0);
        S_WREADY = 1'b1;
        #1;
        check("rst_test_beat1_ready", 128'(M0_WREADY), 128'(1));
        @(negedge ACLK);
        drive_w(1'b0, 1'b1, sq_data[0][1], sq_strb[0][1], 1'b0);
        #1;
        check("rst_test_beat2_visible", 128'(S_WVALID), 128'(1));
        ARESETn = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 128'(0));
        check("async_reset_busy", 128'(busy), 128'(0));
        q_w.delete();
        m_last = 1'b1;
        drive_w(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        S_WREADY = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        run_round(2'b10, 1'b0);

        repeat (5) @(negedge ACLK);
        #1;
        check("queues_drained", 128'({q_aw.size(), q_w.size(), q_b.size()}), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
